// File: rtl/toggle_cover_detect_if.sv
// Bus between a toggle-coverage detector and its driver / consumer.
//   master : drives en, clear, sig; receives the coverage outputs
//   slave  : the detector itself
// Signals: en (sampling enable), clear (coverage clear), sig (monitored
// vector), valid (per-bit toggle pulse), covered (sticky bitmap),
// cover_count (popcount of covered), all_covered, new_hit.
interface toggle_cover_detect_if #(
  parameter int WIDTH = 9
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CW-1:0]    cover_count;
  logic             all_covered;
  logic             new_hit;

  modport master (
    output en, clear, sig,
    input  valid, covered, cover_count, all_covered, new_hit
  );

  modport slave (
    input  en, clear, sig,
    output valid, covered, cover_count, all_covered, new_hit
  );
endinterface

// File: rtl/toggle_cover_detect.sv
// Toggle coverage detector. Samples sig on every enabled cycle and flags
// each bit that changed since the previous enabled sample. Keeps a sticky
// per-bit coverage bitmap with its popcount and an all-covered flag.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low reset of all state
//   bus   : toggle_cover_detect_if.slave (en, clear, sig in;
//           valid, covered, cover_count, all_covered, new_hit out)
// Parameters:
//   WIDTH      : number of monitored bits (must match the interface)
//   FIRST_ONLY : 1 = valid only pulses on the first toggle of each bit
module toggle_cover_detect #(
  parameter int WIDTH      = 9,
  parameter int FIRST_ONLY = 0
) (
  input logic                  clock,
  input logic                  reset,
  toggle_cover_detect_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic [WIDTH-1:0] s_q;
  logic             primed;
  logic [WIDTH-1:0] valid_p1;
  logic [WIDTH-1:0] covered_p1;
  logic [CW-1:0]    cover_count_p1;
  logic             all_covered_p1;
  logic             new_hit_p1;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] covered_next;

  // Stage p0: toggle detection against the last enabled sample. An unprimed
  // sample register holds stale or reset data, so no toggle is reported.
  always_comb begin
    t = '0;
    if (bus.en && primed && !bus.clear) begin
      t = bus.sig ^ s_q;
    end
    hit          = t & ~covered_p1;
    covered_next = covered_p1 | t;
  end

  // Stage p1: registered pulses and coverage state
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_q            <= '0;
      primed         <= 1'b0;
      valid_p1       <= '0;
      covered_p1     <= '0;
      cover_count_p1 <= '0;
      all_covered_p1 <= 1'b0;
      new_hit_p1     <= 1'b0;
    end else if (bus.clear) begin
      if (bus.en) begin
        s_q <= bus.sig;
      end
      primed         <= 1'b0;
      valid_p1       <= '0;
      covered_p1     <= '0;
      cover_count_p1 <= '0;
      all_covered_p1 <= 1'b0;
      new_hit_p1     <= 1'b0;
    end else begin
      if (bus.en) begin
        s_q <= bus.sig;
      end
      primed         <= bus.en;
      valid_p1       <= (FIRST_ONLY != 0) ? hit : t;
      covered_p1     <= covered_next;
      cover_count_p1 <= popcount(covered_next);
      all_covered_p1 <= &covered_next;
      new_hit_p1     <= |hit;
    end
  end

  assign bus.valid       = valid_p1;
  assign bus.covered     = covered_p1;
  assign bus.cover_count = cover_count_p1;
  assign bus.all_covered = all_covered_p1;
  assign bus.new_hit     = new_hit_p1;
endmodule

// File: tb/tb_toggle_cover_detect.sv
// Bench for toggle_cover_detect: two instances (FIRST_ONLY = 0 and 1) are
// driven with identical stimulus. Each step's expected outputs are queued
// when the stimulus is applied and popped/compared after the clock edge.
module tb_toggle_cover_detect;
  localparam int W = 9;

  logic clock;
  logic reset;

  toggle_cover_detect_if #(.WIDTH(W)) ifc0 ();
  toggle_cover_detect_if #(.WIDTH(W)) ifc1 ();

  toggle_cover_detect #(.WIDTH(W), .FIRST_ONLY(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc0.slave)
  );

  toggle_cover_detect #(.WIDTH(W), .FIRST_ONLY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [8:0] sig;
    logic [8:0] v0;   // valid expected with FIRST_ONLY=0
    logic [8:0] v1;   // valid expected with FIRST_ONLY=1
    logic [8:0] cov;
    logic [3:0] cnt;
    logic       all;
    logic       nh;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst, input logic en, input logic clr,
                     input logic [8:0] sig, input logic [8:0] v0,
                     input logic [8:0] v1, input logic [8:0] cov,
                     input logic [3:0] cnt, input logic all, input logic nh);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.sig = sig;
    v.v0 = v0; v.v1 = v1; v.cov = cov; v.cnt = cnt; v.all = all; v.nh = nh;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int step, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    vec_t e;
    @(negedge clock);
    reset     = v.rst;
    ifc0.en   = v.en;  ifc0.clear = v.clr; ifc0.sig = v.sig;
    ifc1.en   = v.en;  ifc1.clear = v.clr; ifc1.sig = v.sig;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    cmp("valid0",       step, int'(ifc0.valid),       int'(e.v0));
    cmp("covered0",     step, int'(ifc0.covered),     int'(e.cov));
    cmp("cover_count0", step, int'(ifc0.cover_count), int'(e.cnt));
    cmp("all_covered0", step, int'(ifc0.all_covered), int'(e.all));
    cmp("new_hit0",     step, int'(ifc0.new_hit),     int'(e.nh));
    cmp("valid1",       step, int'(ifc1.valid),       int'(e.v1));
    cmp("covered1",     step, int'(ifc1.covered),     int'(e.cov));
    cmp("cover_count1", step, int'(ifc1.cover_count), int'(e.cnt));
    cmp("all_covered1", step, int'(ifc1.all_covered), int'(e.all));
    cmp("new_hit1",     step, int'(ifc1.new_hit),     int'(e.nh));
  endtask

  initial begin
    vec_t h;
    reset = 1'b0;
    ifc0.en = 1'b0; ifc0.clear = 1'b0; ifc0.sig = '0;
    ifc1.en = 1'b0; ifc1.clear = 1'b0; ifc1.sig = '0;

    //  rst en clr sig     v0     v1     cov    cnt all nh
    // reset, prime, single-bit toggle
    add(0, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h001, 9'h001, 9'h001, 9'h001, 1, 0, 1);
    add(1, 1, 0, 9'h001, 9'h000, 9'h000, 9'h001, 1, 0, 0);
    // alternating all-bits toggles
    add(0, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9, 1, 1);
    add(1, 1, 0, 9'h000, 9'h1FF, 9'h000, 9'h1FF, 9, 1, 0);
    add(1, 1, 0, 9'h1FF, 9'h1FF, 9'h000, 9'h1FF, 9, 1, 0);
    add(1, 1, 0, 9'h000, 9'h1FF, 9'h000, 9'h1FF, 9, 1, 0);
    // reset mid-stream with full coverage; first sample after reset only primes
    add(0, 1, 0, 9'h1FF, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h0AA, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h0AB, 9'h001, 9'h001, 9'h001, 1, 0, 1);
    // en low while sig changes; re-enable gives no pulse
    add(1, 1, 1, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 0, 0, 9'h0F0, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 0, 0, 9'h0F0, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h0F0, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h0F1, 9'h001, 9'h001, 9'h001, 1, 0, 1);
    // clear coinciding with a toggle: clear wins, then unprimed sample
    add(1, 1, 1, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 8, 0, 1);
    add(1, 1, 0, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 8, 0, 0);
    add(1, 1, 1, 9'h100, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h100, 9'h100, 9'h100, 9'h100, 1, 0, 1);
    // en low forces valid low next cycle, coverage retained
    add(1, 0, 0, 9'h000, 9'h000, 9'h000, 9'h100, 1, 0, 0);
    // reset beats en and clear
    add(0, 1, 1, 9'h1FF, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    // bit 3 toggled three times, then the rest
    add(1, 1, 0, 9'h000, 9'h000, 9'h000, 9'h000, 0, 0, 0);
    add(1, 1, 0, 9'h008, 9'h008, 9'h008, 9'h008, 1, 0, 1);
    add(1, 1, 0, 9'h000, 9'h008, 9'h000, 9'h008, 1, 0, 0);
    add(1, 1, 0, 9'h008, 9'h008, 9'h000, 9'h008, 1, 0, 0);
    add(1, 1, 0, 9'h1FF, 9'h1F7, 9'h1F7, 9'h1FF, 9, 1, 1);
    add(1, 1, 0, 9'h000, 9'h1FF, 9'h000, 9'h1FF, 9, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Clear with en low: s_q holds 0x000, block unprimed; the next enabled
    // sample of 0x1FF must not pulse, and 0x1FE then toggles bit 0 only.
    h.rst = 1; h.en = 0; h.clr = 1; h.sig = 9'h1FF;
    h.v0 = 9'h000; h.v1 = 9'h000; h.cov = 9'h000; h.cnt = 0; h.all = 0; h.nh = 0;
    apply(h, 100);
    h.en = 1; h.clr = 0;
    apply(h, 101);
    h.sig = 9'h1FE; h.v0 = 9'h001; h.v1 = 9'h001; h.cov = 9'h001; h.cnt = 1; h.nh = 1;
    apply(h, 102);
    // same value again: single-cycle pulse must drop
    h.v0 = 9'h000; h.v1 = 9'h000; h.nh = 0;
    apply(h, 103);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/toggle_cover_detect.md
TOGGLE_COVER_DETECT -- requirements
Module: toggle_cover_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 9, giving the number of monitored signal bits.
REQ-002 SHALL have parameter FIRST_ONLY, default 0; when 1, valid pulses only on the first toggle of each bit since reset or clear.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  sampling enable; high means sig is sampled this cycle.
REQ-006 clear  input  1  synchronous clear of coverage state, active-high.
REQ-007 sig  input  WIDTH  monitored signal vector.
REQ-008 valid  output  WIDTH  per-bit toggle pulse, one cycle wide; feeds the downstream toggle-cover reporter valid port.
REQ-009 covered  output  WIDTH  sticky per-bit toggled-at-least-once bitmap.
REQ-010 cover_count  output  $clog2(WIDTH+1)  number of set bits in covered.
REQ-011 all_covered  output  1  high when every covered bit is set.
REQ-012 new_hit  output  1  one-cycle pulse when at least one covered bit goes 0->1.

Function
REQ-013 SHALL hold a sample register s_q (WIDTH) and a primed flag, both updated only on rising clock edges.
REQ-014 On a cycle with en=1 and clear=0, s_q SHALL load sig and primed SHALL become 1.
REQ-015 On a cycle with en=0, s_q SHALL hold, primed SHALL become 0, and valid SHALL be 0 on the next cycle.
REQ-016 The toggle vector SHALL be t = sig XOR s_q, qualified by en=1, primed=1 and clear=0; otherwise t = 0.
REQ-017 If FIRST_ONLY=0, valid SHALL be registered t, so valid is high exactly one cycle after the edge where the changed value was sampled.
REQ-018 If FIRST_ONLY=1, valid SHALL be registered (t AND NOT covered).
REQ-019 covered SHALL update as covered <= covered OR t on the same edge that valid registers.
REQ-020 cover_count SHALL be registered and equal the popcount of the updated covered value on the same edge, so covered and cover_count never disagree.
REQ-021 all_covered SHALL be registered and equal (updated covered == all ones) on the same edge.
REQ-022 new_hit SHALL be registered and equal OR-reduce(t AND NOT covered).
REQ-023 clear=1 SHALL, on the next edge:
  - zero covered, cover_count, all_covered, valid and new_hit;
  - set primed to 0;
  - load s_q from sig if en=1.
REQ-024 When clear and a toggle occur in the same cycle, clear SHALL win: no valid pulse and no coverage update.
REQ-025 The first sampled cycle after reset, clear or en re-assertion SHALL never produce a valid pulse, whatever the value of sig.
REQ-026 Simultaneous toggles on several bits SHALL each produce a valid bit in the same cycle.
REQ-027 cover_count SHALL saturate naturally at WIDTH and never wrap.
REQ-028 The block SHALL be fully synthesizable, with no DPI or simulation-only constructs.

Reset
REQ-029 While reset=0 at a rising edge, the following SHALL all be 0 after that edge: s_q, primed, valid, covered, cover_count, all_covered and new_hit.
REQ-030 Reset SHALL take priority over en and clear.
REQ-031 Reset asserted mid-operation SHALL discard all coverage state, with no pulse emitted in the reset cycle.
REQ-032 The first edge with reset=1 and en=1 SHALL only prime the block (REQ-025).

Verification
REQ-033 WIDTH=9, FIRST_ONLY=0: release reset with en=1, sig=0x000; then sig=0x001 -> valid=0x001 one cycle later, covered=0x001, cover_count=1, new_hit=1.
REQ-034 sig alternating 0x000/0x1FF every cycle for 4 cycles after priming -> valid=0x1FF each cycle; all_covered=1 and cover_count=9 from the first pulse; new_hit only on the first pulse.
REQ-035 FIRST_ONLY=1: toggle bit 3 three times -> exactly one valid pulse (0x008); covered=0x008.
REQ-036 en low for 2 cycles while sig changes 0x000->0x0F0, then en high -> no valid pulse on re-enable; the next change to 0x0F1 gives valid=0x001.
REQ-037 clear=1 in the same cycle as a sig change 0x000->0x100, with covered=0x0FF -> valid=0, covered=0x000, cover_count=0 next cycle; sig=0x000 the following cycle gives no pulse (unprimed).
REQ-038 reset=0 for one cycle mid-stream with covered=0x1FF -> all outputs 0 next cycle; the first post-reset sample gives no pulse.
